sr_readback: RTL and testbench
==============================

Name: sr_readback

Overview:
- Downstream companion of the shift-register write controller.
- Captures the serial stream returning from the far end of the ASIC configuration shift-register chain while a write is being shifted in.
- Deserializes it into a DATA_WIDTH word and compares it bit-by-bit against a reference word. The reference is normally the previously written configuration, so the block verifies the chain contents.
- Started by the same start pulse that drives the write controller. Self-timed thereafter via a fixed delay parameter.

Parameters:
- DATA_WIDTH, 170, number of bits captured per readback.
- CNT_WIDTH, 8, width of the bit and mismatch counters. Must satisfy 2^CNT_WIDTH > DATA_WIDTH.
- SHIFT_DIRECTION, 1, ordering of captured bits. 1: first bit received is MSB. 0: first bit received is LSB.
- DELAY, 1, clock edges between the start-accept edge and the first capture edge, minus one. Range 0..255.

Ports:
- clk  input  1  control clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high module reset.
- start  input  1  begin readback. Sampled only in IDLE.
- sr_in  input  1  serial data from the shift-register chain output.
- expected  input  DATA_WIDTH  reference word. Latched on the start-accept edge.
- dout  output  DATA_WIDTH  last completed captured word.
- valid  output  1  one-cycle pulse: dout and mismatch_cnt updated.
- busy  output  1  readback in progress.
- mismatch  output  1  last completed word had at least one differing bit.
- mismatch_cnt  output  CNT_WIDTH  number of differing bits in the last completed word.

Behaviour:
- Reset values: all outputs 0. This covers dout, valid, busy, mismatch and mismatch_cnt. Internal shift register, latched expected word, counters and state are also cleared. State goes to IDLE.
- Reset mid-operation: capture is abandoned immediately. No valid pulse is produced. Outputs read 0 after reset.
- States: IDLE, WAIT, CAPTURE.
- IDLE:
  - If start=1 at edge E0, latch expected, clear the bit counter and working mismatch counter, and set busy=1.
  - Go to CAPTURE if DELAY=0; otherwise go to WAIT with the delay counter at 0.
  - If start=0, stay in IDLE.
- WAIT: increment the delay counter each edge. At the edge where it reaches DELAY, go to CAPTURE.
- Capture timing: the first bit is sampled at edge E(DELAY+1). Bit k (k=0..DATA_WIDTH-1) is sampled at edge E(DELAY+1+k).
- CAPTURE, on each edge:
  - Sample sr_in into the working shift register.
  - SHIFT_DIRECTION=1: shift left, insert at bit 0. The first bit received ends at dout[DATA_WIDTH-1].
  - SHIFT_DIRECTION=0: shift right, insert at bit DATA_WIDTH-1. The first bit received ends at dout[0].
  - Compare bit k with expected[DATA_WIDTH-1-k] when SHIFT_DIRECTION=1, or with expected[k] when 0.
  - Increment the working mismatch counter if they differ. The counter saturates at 2^CNT_WIDTH-1 and never wraps.
- Completion edge (k = DATA_WIDTH-1):
  - dout receives the final word including this bit.
  - mismatch_cnt receives the final count including this bit's comparison.
  - mismatch is set to (final count != 0).
  - valid=1 for exactly one cycle; busy=0; state goes to IDLE.
- Output hold: dout, mismatch and mismatch_cnt hold their values until the next completion or reset. They do not change during a new capture.
- start while busy: ignored, with no effect on the capture in progress. start high in the valid cycle: accepted, since state is IDLE. A new readback begins at that edge and valid falls normally.
- Changes to expected after the start-accept edge have no effect.
- Latency: valid rises DELAY+DATA_WIDTH+1 edges after the start-accept edge, counting the start-accept edge itself as the first.
- Alignment with the write controller: the first written bit appears on its data_out one edge after start. For a chain of N stages, set DELAY = N-1 plus the number of external pipeline registers.

Test Plan:
- Reset: assert rst asynchronously mid-cycle during CAPTURE -> all outputs 0 immediately; no valid pulse afterward; after release, idle until start.
- Ordering (bench instance DATA_WIDTH=8, DELAY=0, SHIFT_DIRECTION=1): start, then drive sr_in 1,0,1,1,0,0,1,0 from E1 to E8 with expected=8'hB2 -> valid at E8, dout=8'hB2, mismatch=0, mismatch_cnt=0, busy high E0..E8.
- Ordering LSB-first (SHIFT_DIRECTION=0): same stream -> dout=8'h4D; expected=8'hB2 -> mismatch=1, mismatch_cnt=8.
- Delay and mismatch count (DATA_WIDTH=8, DELAY=3): drive garbage before E4, then 8'hFF MSB-first, with expected=8'hF0 -> valid exactly at E11, dout=8'hFF, mismatch_cnt=4.
- Handshake: pulse start during CAPTURE -> ignored, single valid. Hold start high through the valid cycle -> second readback begins at that edge. Previous dout is held until the second valid.
- Default parameters (DATA_WIDTH=170, DELAY=1): loop back the write controller's data_out through one register into sr_in, with expected equal to the written word -> valid 172 edges after start, dout equal to the written word, mismatch=0.

Source files
------------

// File: rtl/sr_readback_if.sv
// sr_readback_if: start/serial/reference inputs and captured-word outputs of the readback block.
interface sr_readback_if #(
    parameter int DATA_WIDTH = 170,
    parameter int CNT_WIDTH  = 8
);
    logic                  start;
    logic                  sr_in;
    logic [DATA_WIDTH-1:0] expected;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  busy;
    logic                  mismatch;
    logic [CNT_WIDTH-1:0]  mismatch_cnt;
    modport master (output start, sr_in, expected, input dout, valid, busy, mismatch, mismatch_cnt);
    modport slave  (input start, sr_in, expected, output dout, valid, busy, mismatch, mismatch_cnt);
endinterface

// File: rtl/sr_readback.sv
// sr_readback: deserializes the returning configuration chain stream and counts bit
// differences against the reference word latched at start.
module sr_readback #(
    parameter int DATA_WIDTH      = 170,
    parameter int CNT_WIDTH       = 8,
    parameter bit SHIFT_DIRECTION = 1'b1,
    parameter int DELAY           = 1
) (
    input logic        clk,
    input logic        rst,
    sr_readback_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE} state_t;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [7:0]           DLY  = 8'(DELAY);
    state_t                state_q, state_d;
    logic [7:0]            dcnt_q, dcnt_d;
    logic [CNT_WIDTH-1:0]  bcnt_q, bcnt_d, wcnt_q, wcnt_d, cnt_q, cnt_d, wcnt_inc;
    logic [DATA_WIDTH-1:0] sh_q, sh_d, exp_q, exp_d, dout_q, dout_d, sh_nx;
    logic                  valid_q, valid_d, busy_q, busy_d, mism_q, mism_d, diff;
    // The latched reference is shifted alongside the capture, so the bit to compare
    // against always sits at the same end of exp_q.
    assign diff     = bus.sr_in ^ (SHIFT_DIRECTION ? exp_q[DATA_WIDTH-1] : exp_q[0]);
    assign wcnt_inc = (diff && wcnt_q != '1) ? wcnt_q + CNT_WIDTH'(1) : wcnt_q;
    assign sh_nx    = SHIFT_DIRECTION ? {sh_q[DATA_WIDTH-2:0], bus.sr_in}
                                      : {bus.sr_in, sh_q[DATA_WIDTH-1:1]};
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        sh_d    = sh_q;
        exp_d   = exp_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        mism_d  = mism_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                exp_d   = bus.expected;
                bcnt_d  = '0;
                wcnt_d  = '0;
                dcnt_d  = '0;
                busy_d  = 1'b1;
                state_d = (DELAY == 0) ? CAPTURE : WAIT;
            end
            WAIT: begin
                dcnt_d  = dcnt_q + 8'd1;
                state_d = (dcnt_d == DLY) ? CAPTURE : WAIT;
            end
            CAPTURE: begin
                sh_d   = sh_nx;
                exp_d  = SHIFT_DIRECTION ? exp_q << 1 : exp_q >> 1;
                wcnt_d = wcnt_inc;
                bcnt_d = bcnt_q + CNT_WIDTH'(1);
                if (bcnt_q == LAST) begin
                    dout_d  = sh_nx;
                    cnt_d   = wcnt_inc;
                    mism_d  = wcnt_inc != '0;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            exp_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            exp_q   <= exp_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            mism_q  <= mism_d;
        end
    end
    assign bus.dout         = dout_q;
    assign bus.valid        = valid_q;
    assign bus.busy         = busy_q;
    assign bus.mismatch     = mism_q;
    assign bus.mismatch_cnt = cnt_q;
endmodule

// File: tb/tb_sr_readback.sv
// tb_sr_readback: four readback instances (MSB/LSB ordering, delayed, full width) driven
// with directed streams; a scoreboard monitor checks every valid pulse.
module tb_sr_readback;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         start_v[4], sr_v[4];
    logic [169:0] exp_v[4], dout_w[4];
    logic [7:0]   cnt_w[4];
    logic         val_w[4], busy_w[4], mism_w[4];

    sr_readback_if #(.DATA_WIDTH(8)) if0 ();
    sr_readback_if #(.DATA_WIDTH(8)) if1 ();
    sr_readback_if #(.DATA_WIDTH(8)) if2 ();
    sr_readback_if                   if3 ();
    sr_readback #(.DATA_WIDTH(8), .DELAY(0), .SHIFT_DIRECTION(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0));
    sr_readback #(.DATA_WIDTH(8), .DELAY(0), .SHIFT_DIRECTION(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1));
    sr_readback #(.DATA_WIDTH(8), .DELAY(3), .SHIFT_DIRECTION(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));
    sr_readback                                                      u3 (.clk(clk), .rst(rst), .bus(if3));

    assign if0.start = start_v[0]; assign if0.sr_in = sr_v[0]; assign if0.expected = exp_v[0][7:0];
    assign if1.start = start_v[1]; assign if1.sr_in = sr_v[1]; assign if1.expected = exp_v[1][7:0];
    assign if2.start = start_v[2]; assign if2.sr_in = sr_v[2]; assign if2.expected = exp_v[2][7:0];
    assign if3.start = start_v[3]; assign if3.sr_in = sr_v[3]; assign if3.expected = exp_v[3];
    assign dout_w[0] = 170'(if0.dout); assign cnt_w[0] = if0.mismatch_cnt; assign val_w[0] = if0.valid;
    assign dout_w[1] = 170'(if1.dout); assign cnt_w[1] = if1.mismatch_cnt; assign val_w[1] = if1.valid;
    assign dout_w[2] = 170'(if2.dout); assign cnt_w[2] = if2.mismatch_cnt; assign val_w[2] = if2.valid;
    assign dout_w[3] = if3.dout;       assign cnt_w[3] = if3.mismatch_cnt; assign val_w[3] = if3.valid;
    assign busy_w[0] = if0.busy; assign busy_w[1] = if1.busy; assign busy_w[2] = if2.busy; assign busy_w[3] = if3.busy;
    assign mism_w[0] = if0.mismatch; assign mism_w[1] = if1.mismatch;
    assign mism_w[2] = if2.mismatch; assign mism_w[3] = if3.mismatch;

    typedef struct {
        logic [169:0] dout;
        logic [7:0]   cnt;
        int           cyc;
    } exp_t;
    exp_t sbq[4][$];
    exp_t e;
    int compared = 0, mismatched = 0;

    task automatic cmp(input string nm, input int id, input logic [169:0] act, input logic [169:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s inst%0d cyc=%0d got=%0h want=%0h", nm, id, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (val_w[i] === 1'b1) begin
            if (sbq[i].size() == 0) begin
                cmp("unexpected_valid", i, 170'd1, 170'd0);
            end else begin
                e = sbq[i].pop_front();
                cmp("dout", i, dout_w[i], e.dout);
                cmp("mismatch_cnt", i, 170'(cnt_w[i]), 170'(e.cnt));
                cmp("mismatch", i, 170'(mism_w[i]), 170'(e.cnt != 8'd0));
                cmp("valid_cycle", i, 170'(cyc), 170'(e.cyc));
            end
        end
    end

    // Called just after a negedge; bit k of the stream is stream[dw-1-k].
    task automatic run(input int id, input int dw, input int dly, input logic [169:0] stream,
                       input logic [169:0] expw, input logic [169:0] dexp, input logic [7:0] cexp,
                       input bit hold, input bit chk_hold, input logic [169:0] prev);
        exp_t t;
        start_v[id] = 1'b1;
        exp_v[id]   = expw;
        t.dout = dexp; t.cnt = cexp; t.cyc = cyc + 1 + dly + dw;
        sbq[id].push_back(t);
        for (int j = 0; j < dly + dw; j++) begin
            @(negedge clk);
            cmp("busy_during", id, 170'(busy_w[id]), 170'd1);
            if (chk_hold && j == dly + dw / 2) cmp("dout_held", id, dout_w[id], prev);
            start_v[id] = hold;
            exp_v[id]   = ~expw;
            sr_v[id]    = (j < dly) ? 1'($urandom) : stream[dw - 1 - (j - dly)];
        end
        @(negedge clk);
        cmp("busy_done", id, 170'(busy_w[id]), 170'd0);
        if (!hold) start_v[id] = 1'b0;
    endtask

    logic [169:0] w;
    initial begin
        for (int i = 0; i < 4; i++) begin start_v[i] = 0; sr_v[i] = 0; exp_v[i] = '0; end
        w = {2'b10, {21{8'hA5}}};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cmp("rst_dout", i, dout_w[i], 170'd0);
            cmp("rst_flags", i, 170'({val_w[i], busy_w[i], mism_w[i]}), 170'd0);
            cmp("rst_cnt", i, 170'(cnt_w[i]), 170'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run(0, 8, 0, 170'hB2, 170'hB2, 170'hB2, 8'd0, 0, 0, '0);
        run(1, 8, 0, 170'hB2, 170'hB2, 170'h4D, 8'd8, 0, 0, '0);
        run(2, 8, 3, 170'hFF, 170'hF0, 170'hFF, 8'd4, 0, 0, '0);
        run(0, 8, 0, 170'h5A, 170'h5A, 170'h5A, 8'd0, 1, 0, '0);
        run(0, 8, 0, 170'h0F, 170'hF0, 170'h0F, 8'd8, 0, 1, 170'h5A);
        run(1, 8, 0, 170'hB2, 170'h4D, 170'h4D, 8'd0, 0, 0, '0);
        run(3, 170, 1, w, w, w, 8'd0, 0, 0, '0);
        run(3, 170, 1, w, w ^ 170'h7, w, 8'd3, 0, 1, w);
        @(negedge clk);
        start_v[0] = 1'b1; exp_v[0] = 170'h11;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            start_v[0] = 1'b0; sr_v[0] = 1'b1;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        cmp("rst_async_dout", 0, dout_w[0], 170'd0);
        cmp("rst_async_flags", 0, 170'({val_w[0], busy_w[0], mism_w[0]}), 170'd0);
        cmp("rst_async_cnt", 0, 170'(cnt_w[0]), 170'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        cmp("idle_after_rst", 0, 170'(busy_w[0]), 170'd0);
        for (int i = 0; i < 4; i++) cmp("sb_drained", i, 170'(sbq[i].size()), 170'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
